// File: rtl/tdpram_pkg.sv
// Shared types and defaults for the true-dual-port RAM BIST controller.
package tdpram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_WA_RA  = 2'd0,
    MODE_WA_RB  = 2'd1,
    MODE_WB_RA  = 2'd2,
    MODE_WA_RAB = 2'd3
  } mode_e;

  localparam int unsigned DEFAULT_STRIDE = 32'h25;

endpackage

// File: rtl/tdpram_bist_checker.sv
// Expected-data pipeline for one RAM read port; flags a mismatch when the
// read data returns READ_LAT cycles after the address was issued.
module tdpram_bist_checker
  import tdpram_pkg::*;
#(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_i,
  input  logic [DATA_W-1:0] exp_data_i,
  input  logic [ADDR_W-1:0] exp_addr_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic              mismatch_o,
  output logic [ADDR_W-1:0] mm_addr_o
);

  logic [READ_LAT-1:0] vld_q;
  logic [DATA_W-1:0]   dat_q [READ_LAT];
  logic [ADDR_W-1:0]   adr_q [READ_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        dat_q[i] <= '0;
        adr_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= issue_i;
      dat_q[0] <= exp_data_i;
      adr_q[0] <= exp_addr_i;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
    end
  end

  always_comb begin
    mismatch_o = vld_q[READ_LAT-1] && (dout_i != dat_q[READ_LAT-1]);
    mm_addr_o  = adr_q[READ_LAT-1];
  end

endmodule

// File: rtl/tdpram_bist.sv
// March-style BIST for a true-dual-port RAM: writes an arithmetic pattern
// through one port, reads it back through one or both ports and counts errors.
module tdpram_bist
  import tdpram_pkg::*;
#(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned STRIDE   = DEFAULT_STRIDE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic              we_a,
  output logic              we_b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] din_b,
  input  logic [DATA_W-1:0] dout_a,
  input  logic [DATA_W-1:0] dout_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 2;
  localparam int unsigned ERR_W = ADDR_W + 2;
  localparam logic [DATA_W-1:0] STRIDE_W   = DATA_W'(STRIDE);
  localparam logic [CNT_W-1:0]  LAST_ADDR  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_FLUSH = CNT_W'(READ_LAT - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              seen_q, seen_d;
  logic              pass_q, pass_d;

  logic              wr_b, rd_a, rd_b;
  logic              issue_a, issue_b;
  logic              mm_a, mm_b;
  logic [ADDR_W-1:0] mm_addr_a, mm_addr_b;
  logic [ERR_W:0]    err_sum;

  always_comb begin
    wr_b    = (mode_q == MODE_WB_RA);
    rd_a    = (mode_q != MODE_WA_RB);
    rd_b    = (mode_q == MODE_WA_RB) || (mode_q == MODE_WA_RAB);
    issue_a = (state_q == ST_READ) && rd_a;
    issue_b = (state_q == ST_READ) && rd_b;
  end

  tdpram_bist_checker #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_chk_a (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (issue_a),
    .exp_data_i (pat_q),
    .exp_addr_i (cnt_q[ADDR_W-1:0]),
    .dout_i     (dout_a),
    .mismatch_o (mm_a),
    .mm_addr_o  (mm_addr_a)
  );

  tdpram_bist_checker #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_chk_b (
    .clk        (clk),
    .rst        (rst),
    .issue_i    (issue_b),
    .exp_data_i (pat_q),
    .exp_addr_i (cnt_q[ADDR_W-1:0]),
    .dout_i     (dout_b),
    .mismatch_o (mm_b),
    .mm_addr_o  (mm_addr_b)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    seed_d  = seed_q;
    pass_d  = pass_q;

    // One extra bit of headroom so two simultaneous errors can saturate cleanly
    err_sum = {1'b0, err_q} + {{ERR_W{1'b0}}, mm_a} + {{ERR_W{1'b0}}, mm_b};
    err_d   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    seen_d  = seen_q || mm_a || mm_b;
    ferr_d  = ferr_q;
    if (!seen_q && (mm_a || mm_b)) begin
      ferr_d = mm_a ? mm_addr_a : mm_addr_b;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WRITE;
          mode_d  = mode_e'(mode);
          seed_d  = seed;
          pat_d   = seed;
          cnt_d   = '0;
          err_d   = '0;
          ferr_d  = '0;
          seen_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        pat_d = pat_q + STRIDE_W;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READ;
          cnt_d   = '0;
          pat_d   = seed_q;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + 1'b1;
        pat_d = pat_q + STRIDE_W;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_FLUSH) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          pass_d  = (err_d == '0);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_WA_RA;
      cnt_q   <= '0;
      pat_q   <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      seen_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      seen_q  <= seen_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    we_a   = 1'b0;
    we_b   = 1'b0;
    addr_a = '0;
    addr_b = '0;
    din_a  = '0;
    din_b  = '0;
    case (state_q)
      ST_WRITE: begin
        if (wr_b) begin
          we_b   = 1'b1;
          addr_b = cnt_q[ADDR_W-1:0];
          din_b  = pat_q;
        end else begin
          we_a   = 1'b1;
          addr_a = cnt_q[ADDR_W-1:0];
          din_a  = pat_q;
        end
      end
      ST_READ: begin
        if (rd_a) addr_a = cnt_q[ADDR_W-1:0];
        if (rd_b) addr_b = cnt_q[ADDR_W-1:0];
      end
      default: ;
    endcase
    busy           = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_FLUSH);
    done           = (state_q == ST_DONE);
    pass           = pass_q;
    err_count      = err_q;
    first_err_addr = ferr_q;
  end

endmodule

// File: doc/tdpram_bist.md
TDPRAM_BIST -- requirements
Module: tdpram_bist

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 3, meaning address width, with DEPTH = 2**ADDR_W.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the RAM word width.
REQ-003 The block SHALL have parameter READ_LAT, default 1, range 1..4, meaning RAM read latency in clk cycles.
REQ-004 The block SHALL have parameter STRIDE, default 8'h25, odd and zero-extended to DATA_W, meaning the pattern increment.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-008 The block SHALL have port mode, input, 2 bits, captured at start: 0 = write A/read A; 1 = write A/read B; 2 = write B/read A; 3 = write A/read A and B.
REQ-009 The block SHALL have port seed, input, DATA_W bits, captured at start.
REQ-010 The block SHALL have ports we_a/we_b, output, 1 bit each: write enables, high = write.
REQ-011 The block SHALL have ports addr_a/addr_b, output, ADDR_W bits each.
REQ-012 The block SHALL have ports din_a/din_b, output, DATA_W bits each.
REQ-013 The block SHALL have ports dout_a/dout_b, input, DATA_W bits each: RAM read data.
REQ-014 The block SHALL have port busy, output, 1 bit: high from the cycle after start acceptance until DONE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse at end of run.
REQ-016 The block SHALL have port pass, output, 1 bit: valid from done until the next start.
REQ-017 The block SHALL have port err_count, output, ADDR_W+2 bits: saturating mismatch count.
REQ-018 The block SHALL have port first_err_addr, output, ADDR_W bits: address of the first mismatch.

Function
REQ-019 The FSM SHALL have states IDLE, WRITE, READ, FLUSH, DONE; IDLE -> WRITE on start; WRITE -> READ after DEPTH cycles; READ -> FLUSH after DEPTH cycles; FLUSH -> DONE after READ_LAT cycles; DONE -> IDLE after one cycle.
REQ-020 The pattern SHALL be data(i) = seed + i*STRIDE mod 2**DATA_W, for i = 0..DEPTH-1.
REQ-021 In WRITE cycle i, the write port SHALL drive we=1, addr=i, din=data(i); the other port SHALL hold we=0.
REQ-022 In READ cycle i, the read port(s) SHALL drive we=0, addr=i; data(i) and i SHALL enter a READ_LAT-deep expected pipeline.
REQ-023 Read data SHALL be compared with the expected data exactly READ_LAT cycles after issue; in mode 3 both ports SHALL be compared, and each port mismatch SHALL count separately.
REQ-024 On a mismatch, err_count SHALL increment and saturate at all-ones; first_err_addr SHALL latch only on the first mismatch of the run, with the port A mismatch taking priority when both ports mismatch at once.
REQ-025 done SHALL assert in the cycle 2*DEPTH+READ_LAT+1 after the start-sampling edge; pass SHALL be (err_count==0) at done.
REQ-026 start SHALL be ignored outside IDLE; mode and seed changes during a run SHALL have no effect.
REQ-027 A new start SHALL clear err_count, first_err_addr and pass.
REQ-028 In IDLE, FLUSH and DONE, we_a and we_b SHALL be 0, and addr/din SHALL hold 0.

Reset
REQ-029 While rst is high, all outputs SHALL be 0, the FSM SHALL be IDLE and the pipeline SHALL be cleared.
REQ-030 rst asserted mid-run SHALL abort the run with no done pulse; we_a and we_b SHALL be 0 from the next edge.

Structure
REQ-031 Package tdpram_pkg SHALL hold the FSM state enum, the mode enum and the default STRIDE constant.
REQ-032 The expected-data pipeline and the compare logic SHALL be sub-module tdpram_bist_checker, instantiated once per read port.

Verification
REQ-033 Default parameters, behavioural RAM with READ_LAT=1, mode 0, seed 8'h00 -> writes 00,25,4A,6F,94,B9,DE,03 to addresses 0..7; done at cycle 18; pass=1; err_count=0.
REQ-034 Mode 1, RAM port B bit0 stuck-at-0 at address 5 (expected B9) -> err_count=1, first_err_addr=5, pass=0.
REQ-035 Mode 3, fault on port B only at address 2 -> err_count=1, first_err_addr=2; a fault on both ports at address 2 -> err_count=2.
REQ-036 start pulsed again at WRITE cycle 3 -> ignored; exactly one done pulse at cycle 18.
REQ-037 rst at WRITE cycle 5 -> we_a=0 and busy=0 next cycle, no done pulse; a following start completes with pass=1.
REQ-038 ADDR_W=4, DATA_W=16, READ_LAT=3, seed 16'hFFF0 -> pattern wraps mod 2**16 with no false errors; done at cycle 36.
